// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file writeback arbiter: ALU results vs. queued load results
// Loads wait in a small FIFO; ALU wins by default, starvation forces a load pop.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic [31:0] pending_mask,
    output logic        alu_stall,
    output logic        wb_conflict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_next;
    logic             empty;
    logic             push;
    logic             pop;
    logic             alu_write;
    logic             conflict;

    assign empty     = (count == '0);
    assign mem_ready = rst && (count < CW'(DEPTH));
    assign push      = mem_valid && mem_ready;
    // A forced pop during alu_stall preempts the ALU; with an empty FIFO the ALU is served.
    assign pop       = !empty && (alu_stall || !alu_valid);
    assign alu_write = alu_valid && !(alu_stall && !empty);
    assign conflict  = alu_valid && (alu_stall || pending_mask[alu_rd]);

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) pending_mask[fifo_rd[i]] = 1'b1;
        end
    end

    always_comb begin
        starve_next = '0;
        if (!empty && !pop) starve_next = starve_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
            slot_valid  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            alu_stall   <= 1'b0;
            wb_conflict <= 1'b0;
            WE3         <= 1'b0;
            A3          <= '0;
            WD3         <= '0;
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]    <= mem_rd;
                fifo_data[wr_ptr]  <= mem_data;
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            WE3 <= pop || alu_write;
            if (pop) begin
                A3  <= fifo_rd[rd_ptr];
                WD3 <= fifo_data[rd_ptr];
            end else if (alu_write) begin
                A3  <= alu_rd;
                WD3 <= alu_data;
            end

            starve_cnt  <= starve_next;
            alu_stall   <= (starve_next == SW'(STARVE_LIMIT));
            wb_conflict <= conflict;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] pending_mask;
    logic        alu_stall;
    logic        wb_conflict;

    int    n_checks = 0;
    int    n_fail   = 0;
    string tag      = "init";

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic [31:0] mask;
        logic        conf;
        logic        full;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[16];

    writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .A3(A3), .WD3(WD3), .WE3(WE3), .pending_mask(pending_mask),
        .alu_stall(alu_stall), .wb_conflict(wb_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                input logic [31:0] mask, input logic conf, input logic full);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = ad;
        v.mv = mv; v.mrd = mrd; v.mdata = md;
        v.we = we; v.a3 = a3; v.wd3 = wd;
        v.mask = mask; v.conf = conf; v.full = full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    // Drive one cycle, queue its expectation, compare once the edge has produced the result.
    task automatic apply(input vec_t v);
        vec_t e;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdata;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("WE3", 32'(WE3), 32'(e.we));
        if (e.we || e.full) begin
            chk("A3", 32'(A3), 32'(e.a3));
            chk("WD3", WD3, e.wd3);
        end
        if (e.full) begin
            chk("pending_mask", pending_mask, e.mask);
            chk("mem_ready", 32'(mem_ready), 32'd1);
            chk("alu_stall", 32'(alu_stall), 32'd0);
            chk("wb_conflict", 32'(wb_conflict), 32'(e.conf));
        end
    endtask

    initial begin
        vec_t v;
        logic [4:0]  erd;
        logic [31:0] ewd;

        rst = 1'b0;
        drive_idle();
        #2;
        tag = "reset";
        chk("WE3", 32'(WE3), 32'd0);
        chk("A3", 32'(A3), 32'd0);
        chk("WD3", WD3, 32'd0);
        chk("pending_mask", pending_mask, 32'd0);
        chk("mem_ready", 32'(mem_ready), 32'd0);
        chk("alu_stall", 32'(alu_stall), 32'd0);
        chk("wb_conflict", 32'(wb_conflict), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mem_ready_release", 32'(mem_ready), 32'd1);

        // av ard adata | mv mrd mdata | we a3 wd3 | mask conf full
        tbl[0]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 0,            32'h0,   0, 1);
        tbl[1]  = mk(1, 9, 32'h20, 0, 0, 0,           1, 9, 32'h20,       32'h0,   0, 1);
        tbl[2]  = mk(0, 0, 0,     0, 0, 0,            0, 9, 32'h20,       32'h0,   0, 1);
        tbl[3]  = mk(1, 1, 32'h11, 1, 3, 32'hDEADBEEF, 1, 1, 32'h11,      32'h8,   0, 1);
        tbl[4]  = mk(1, 2, 32'h22, 0, 0, 0,           1, 2, 32'h22,       32'h8,   0, 1);
        tbl[5]  = mk(1, 4, 32'h44, 0, 0, 0,           1, 4, 32'h44,       32'h8,   0, 1);
        tbl[6]  = mk(0, 0, 0,     0, 0, 0,            1, 3, 32'hDEADBEEF, 32'h0,   0, 1);
        tbl[7]  = mk(0, 0, 0,     0, 0, 0,            0, 3, 32'hDEADBEEF, 32'h0,   0, 1);
        tbl[8]  = mk(0, 0, 0,     1, 5, 32'h55,       0, 3, 32'hDEADBEEF, 32'h20,  0, 1);
        tbl[9]  = mk(1, 5, 32'h99, 0, 0, 0,           1, 5, 32'h99,       32'h20,  1, 1);
        tbl[10] = mk(1, 6, 32'h66, 0, 0, 0,           1, 6, 32'h66,       32'h20,  0, 1);
        tbl[11] = mk(0, 0, 0,     0, 0, 0,            1, 5, 32'h55,       32'h0,   0, 1);
        tbl[12] = mk(0, 0, 0,     1, 7, 32'h77,       0, 5, 32'h55,       32'h80,  0, 1);
        tbl[13] = mk(0, 0, 0,     1, 8, 32'h88,       1, 7, 32'h77,       32'h100, 0, 1);
        tbl[14] = mk(0, 0, 0,     0, 0, 0,            1, 8, 32'h88,       32'h0,   0, 1);
        tbl[15] = mk(0, 0, 0,     0, 0, 0,            0, 8, 32'h88,       32'h0,   0, 1);
        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("row%0d", i);
            apply(tbl[i]);
        end

        // Continuous ALU traffic: fill the FIFO, hold a fifth load, starvation forces pops.
        for (int n = 0; n < 19; n++) begin
            tag = $sformatf("starve%0d", n);
            if (n == 3)             chk("mem_ready", 32'(mem_ready), 32'd1);
            if (n >= 4 && n <= 9)   chk("mem_ready", 32'(mem_ready), 32'd0);
            if (n == 10)            chk("mem_ready", 32'(mem_ready), 32'd1);
            if (n == 8 || n == 10)  chk("alu_stall", 32'(alu_stall), 32'd0);
            if (n == 9 || n == 18)  chk("alu_stall", 32'(alu_stall), 32'd1);
            if (n == 9) begin
                erd = 5'd16; ewd = 32'hA0;
            end else if (n == 18) begin
                erd = 5'd17; ewd = 32'hA1;
            end else begin
                erd = 5'(1 + n % 8); ewd = 32'h1000 + 32'(n);
            end
            v = mk(1, 5'(1 + n % 8), 32'h1000 + 32'(n),
                   (n <= 10), 5'(16 + ((n < 4) ? n : 4)), 32'hA0 + 32'((n < 4) ? n : 4),
                   1, erd, ewd, 32'h0, 0, 0);
            apply(v);
            if (n == 3)  chk("pending_mask", pending_mask, 32'h000F0000);
            if (n == 9 || n == 18) chk("wb_conflict", 32'(wb_conflict), 32'd1);
            if (n == 10) begin
                chk("wb_conflict", 32'(wb_conflict), 32'd0);
                chk("pending_mask", pending_mask, 32'h001E0000);
            end
        end
        tag = "drain";
        apply(mk(0, 0, 0, 0, 0, 0, 1, 18, 32'hA2, 32'h0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 19, 32'hA3, 32'h0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 20, 32'hA4, 32'h0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 20, 32'hA4, 32'h0, 0, 1));

        // Asynchronous reset mid-cycle with two loads queued.
        tag = "async_reset";
        apply(mk(1, 1, 32'h1, 1, 20, 32'hB0, 1, 1, 32'h1, 32'h0, 0, 0));
        apply(mk(1, 2, 32'h2, 1, 21, 32'hB1, 1, 2, 32'h2, 32'h0, 0, 0));
        chk("pending_mask_pre", pending_mask, 32'h00300000);
        #3;
        rst = 1'b0;
        #1;
        chk("WE3", 32'(WE3), 32'd0);
        chk("A3", 32'(A3), 32'd0);
        chk("WD3", WD3, 32'd0);
        chk("pending_mask", pending_mask, 32'd0);
        chk("mem_ready", 32'(mem_ready), 32'd0);
        chk("alu_stall", 32'(alu_stall), 32'd0);
        drive_idle();
        @(posedge clk);
        #1;
        chk("WE3_in_reset", 32'(WE3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mem_ready_release", 32'(mem_ready), 32'd1);
        tag = "post_reset";
        for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1));

        tag = "end";
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
